// File: rtl/ysyx_rf_scoreboard.sv
// rtl/ysyx_rf_scoreboard.sv - per-register in-flight writer scoreboard with RAW hazard and forward verdict
module ysyx_rf_scoreboard #(
    parameter int REG_NUM      = 16,
    parameter int REG_LEN      = 4,
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = 4,
    parameter int IW           = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               issue_valid,
    input  logic               issue_wen,
    input  logic [REG_LEN-1:0] issue_rd,
    output logic               issue_ready,
    input  logic               wb_valid,
    input  logic [REG_LEN-1:0] wb_rd,
    input  logic               flush,
    input  logic [REG_LEN-1:0] rs1,
    input  logic [REG_LEN-1:0] rs2,
    input  logic               exu_fwd_valid,
    input  logic [REG_LEN-1:0] exu_fwd_rd,
    output logic [REG_NUM-1:0] rf_table,
    output logic               hazard,
    output logic               fwd1,
    output logic               fwd2,
    output logic [IW-1:0]      inflight,
    output logic               wb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [IW-1:0]    INF_MAX = IW'(MAX_INFLIGHT);

    logic [CNT_W-1:0]   cnt [REG_NUM];
    logic [REG_NUM-1:0] inc_vec;
    logic [REG_NUM-1:0] dec_vec;
    logic               issue_wr;
    logic               inc_any;
    logic               dec_any;
    logic               wb_bad;
    logic               hit1;
    logic               hit2;

    assign issue_wr    = issue_wen && (issue_rd != '0);
    assign issue_ready = !(issue_wr && ((cnt[issue_rd] == CNT_MAX) || (inflight == INF_MAX)));
    assign wb_bad      = wb_valid && (wb_rd != '0) && (cnt[wb_rd] == '0);

    // A same-register issue+writeback pair is treated as a matched inc/dec so it cancels.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 1; i < REG_NUM; i++) begin
            inc_vec[i] = issue_valid && issue_ready && issue_wr && (issue_rd == REG_LEN'(i));
            dec_vec[i] = wb_valid && (wb_rd == REG_LEN'(i)) && ((cnt[i] != '0) || inc_vec[i]);
        end
    end

    assign inc_any = |inc_vec;
    assign dec_any = |dec_vec;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_NUM; i++) cnt[i] <= '0;
            inflight <= '0;
            wb_err   <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < REG_NUM; i++) cnt[i] <= '0;
            inflight <= '0;
        end else begin
            if (wb_bad) wb_err <= 1'b1;
            for (int i = 1; i < REG_NUM; i++) begin
                if (inc_vec[i] && !dec_vec[i])      cnt[i] <= cnt[i] + CNT_ONE;
                else if (dec_vec[i] && !inc_vec[i]) cnt[i] <= cnt[i] - CNT_ONE;
            end
            if (inc_any && !dec_any)      inflight <= inflight + IW'(1);
            else if (dec_any && !inc_any) inflight <= inflight - IW'(1);
        end
    end

    always_comb begin
        rf_table = '0;
        for (int i = 0; i < REG_NUM; i++) rf_table[i] = (cnt[i] != '0);
    end

    // Forwarding is only trusted when exactly one writer is outstanding.
    assign hit1   = exu_fwd_valid && (rs1 == exu_fwd_rd) && (rs1 != '0) && (cnt[rs1] == CNT_ONE);
    assign hit2   = exu_fwd_valid && (rs2 == exu_fwd_rd) && (rs2 != '0) && (cnt[rs2] == CNT_ONE);
    assign fwd1   = hit1;
    assign fwd2   = hit2;
    assign hazard = ((cnt[rs1] != '0) && !hit1) || ((cnt[rs2] != '0) && !hit2);

endmodule

// File: tb/tb_ysyx_rf_scoreboard.sv
// tb/tb_ysyx_rf_scoreboard.sv - directed self-checking bench for ysyx_rf_scoreboard
module tb_ysyx_rf_scoreboard;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid, issue_wen, issue_ready;
    logic [3:0]  issue_rd;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic        flush;
    logic [3:0]  rs1, rs2;
    logic        exu_fwd_valid;
    logic [3:0]  exu_fwd_rd;
    logic [15:0] rf_table;
    logic        hazard, fwd1, fwd2, wb_err;
    logic [2:0]  inflight;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ysyx_rf_scoreboard dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .rs1(rs1), .rs2(rs2), .exu_fwd_valid(exu_fwd_valid), .exu_fwd_rd(exu_fwd_rd),
        .rf_table(rf_table), .hazard(hazard), .fwd1(fwd1), .fwd2(fwd2),
        .inflight(inflight), .wb_err(wb_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [3:0] rd);
        issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = rd;
        step();
        issue_valid = 1'b0; issue_wen = 1'b0; issue_rd = '0;
    endtask

    task automatic wb(input logic [3:0] rd);
        wb_valid = 1'b1; wb_rd = rd;
        step();
        wb_valid = 1'b0; wb_rd = '0;
    endtask

    initial begin
        reset = 1'b0;
        issue_valid = 1'b0; issue_wen = 1'b0; issue_rd = '0;
        wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
        rs1 = '0; rs2 = '0; exu_fwd_valid = 1'b0; exu_fwd_rd = '0;
        step();
        step();
        reset = 1'b1;
        #1;
        check("reset_rf_table", rf_table, 32'h0);
        check("reset_inflight", inflight, 32'h0);
        check("reset_ready", issue_ready, 32'h1);
        check("reset_hazard", hazard, 32'h0);
        check("reset_wb_err", wb_err, 32'h0);
        check("reset_fwd1", fwd1, 32'h0);

        // two writers to r5: forwarding refused, then accepted after one retires
        issue(4'd5);
        issue(4'd5);
        rs1 = 4'd5; exu_fwd_valid = 1'b1; exu_fwd_rd = 4'd5;
        #1;
        check("r5x2_rf_table", rf_table, 32'h0020);
        check("r5x2_inflight", inflight, 32'h2);
        check("r5x2_fwd1", fwd1, 32'h0);
        check("r5x2_hazard", hazard, 32'h1);
        wb(4'd5);
        check("r5x1_fwd1", fwd1, 32'h1);
        check("r5x1_hazard", hazard, 32'h0);
        check("r5x1_inflight", inflight, 32'h1);
        rs2 = 4'd5;
        #1;
        check("r5x1_fwd2", fwd2, 32'h1);
        exu_fwd_valid = 1'b0;
        #1;
        check("r5x1_nofwd_hazard", hazard, 32'h1);
        check("r5x1_nofwd_fwd1", fwd1, 32'h0);
        wb(4'd5);
        check("r5_drained_rf", rf_table, 32'h0);
        check("r5_drained_hazard", hazard, 32'h0);
        rs1 = '0; rs2 = '0; exu_fwd_rd = '0;

        // per-register and global saturation
        issue(4'd3);
        issue(4'd3);
        issue(4'd3);
        check("r3x3_inflight", inflight, 32'h3);
        issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 4'd3;
        #1;
        check("r3_sat_ready", issue_ready, 32'h0);
        step();
        check("r3_sat_no_fire", inflight, 32'h3);
        issue_rd = 4'd7;
        #1;
        check("r7_ready", issue_ready, 32'h1);
        step();
        check("r7_inflight", inflight, 32'h4);
        check("r7_rf_table", rf_table, 32'h0088);
        issue_rd = 4'd8;
        #1;
        check("global_sat_ready", issue_ready, 32'h0);
        issue_wen = 1'b0;
        #1;
        check("nowrite_ready", issue_ready, 32'h1);
        issue_wen = 1'b1; issue_rd = 4'd0;
        #1;
        check("rd0_ready", issue_ready, 32'h1);
        step();
        check("rd0_inflight", inflight, 32'h4);
        issue_valid = 1'b0; issue_wen = 1'b0; issue_rd = '0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush1_inflight", inflight, 32'h0);
        check("flush1_rf_table", rf_table, 32'h0);

        // same-cycle issue and writeback to r6 cancel
        issue(4'd6);
        issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 4'd6;
        wb_valid = 1'b1; wb_rd = 4'd6;
        step();
        issue_valid = 1'b0; issue_wen = 1'b0; issue_rd = '0;
        wb_valid = 1'b0; wb_rd = '0;
        check("same_rf_table", rf_table, 32'h0040);
        check("same_inflight", inflight, 32'h1);
        wb(4'd6);
        check("same_drain_rf", rf_table, 32'h0);
        check("same_drain_inflight", inflight, 32'h0);
        issue(4'd0);
        check("issue_rd0_inflight", inflight, 32'h0);
        wb(4'd0);
        check("wb_rd0_no_err", wb_err, 32'h0);

        // flush beats concurrent issue/writeback
        issue(4'd2);
        issue(4'd4);
        check("pre_flush_rf", rf_table, 32'h0014);
        check("pre_flush_inflight", inflight, 32'h2);
        flush = 1'b1;
        issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 4'd2;
        wb_valid = 1'b1; wb_rd = 4'd4;
        step();
        wb_rd = 4'd9;
        step();
        flush = 1'b0;
        issue_valid = 1'b0; issue_wen = 1'b0; issue_rd = '0;
        wb_valid = 1'b0; wb_rd = '0;
        check("flush2_rf", rf_table, 32'h0);
        check("flush2_inflight", inflight, 32'h0);
        check("flush2_no_err", wb_err, 32'h0);

        // stray writeback sets sticky wb_err
        wb(4'd9);
        check("wb_err_set", wb_err, 32'h1);
        check("wb_err_inflight", inflight, 32'h0);
        check("wb_err_rf", rf_table, 32'h0);
        issue(4'd1);
        wb(4'd1);
        check("wb_err_sticky", wb_err, 32'h1);
        check("wb_err_traffic_inflight", inflight, 32'h0);

        // asynchronous reset mid-traffic
        issue(4'd10);
        issue(4'd10);
        check("pre_reset_inflight", inflight, 32'h2);
        reset = 1'b0;
        #2;
        check("async_inflight", inflight, 32'h0);
        check("async_rf", rf_table, 32'h0);
        check("async_wb_err", wb_err, 32'h0);
        reset = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_rf_scoreboard.md
Name: ysyx_rf_scoreboard

Overview:
Register-file scoreboard controller that owns the per-register busy state used by the decode stage for RAW hazard detection.
- Counts in-flight writers per architectural register.
- Gates issue when a count or the global in-flight budget saturates.
- Produces the rf_table busy vector and a decode-side hazard verdict that accounts for EXU forwarding.
- Sits between decode/issue and writeback; cleared on pipeline flush.

Parameters:
REG_NUM, 16, number of architectural registers (`YSYX_REG_NUM)
REG_LEN, 4, register index width (`YSYX_REG_LEN)
CNT_W, 2, per-register writer counter width; max per-register count = 2^CNT_W-1
MAX_INFLIGHT, 4, maximum total outstanding register writes

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
issue_valid  input  1  decode presents an instruction for issue
issue_wen  input  1  issuing instruction writes rd
issue_rd  input  REG_LEN  destination register of issuing instruction
issue_ready  output  1  scoreboard accepts the issue this cycle
wb_valid  input  1  writeback retires a register write
wb_rd  input  REG_LEN  register being written back
flush  input  1  pipeline flush; discards all pending writes
rs1  input  REG_LEN  decode source register 1
rs2  input  REG_LEN  decode source register 2
exu_fwd_valid  input  1  EXU result is available for forwarding
exu_fwd_rd  input  REG_LEN  EXU forwarding destination
rf_table  output  REG_NUM  bit i = cnt[i] != 0
hazard  output  1  decode must stall for a source operand
fwd1  output  1  rs1 is served from the EXU forward path
fwd2  output  1  rs2 is served from the EXU forward path
inflight  output  $clog2(MAX_INFLIGHT+1)  total outstanding writes
wb_err  output  1  sticky: writeback arrived for a register with count 0

Behaviour:
Reset (reset==0, async):
- All counters cleared; inflight=0; wb_err=0.
- Outputs therefore: rf_table=0, hazard=0, fwd1=fwd2=0.
- issue_ready=1 whenever reset is deasserted and no saturation applies.

Issue fire: issue_valid && issue_ready.
- When issue_wen && issue_rd!=0, the fire increments cnt[issue_rd] and inflight.
- Issues with rd==0 or !issue_wen never change state. Register 0 is never tracked: cnt[0] stays 0.

issue_ready is combinational and equals !(issue_wen && issue_rd!=0 && (cnt[issue_rd]==2^CNT_W-1 || inflight==MAX_INFLIGHT)).
- Non-writing issues are always ready.

Writeback: wb_valid with wb_rd!=0.
- cnt[wb_rd]!=0: decrement cnt[wb_rd] and inflight.
- cnt[wb_rd]==0: no count change; set wb_err (sticky until reset).
- wb_rd==0: ignored.

Same cycle, same register: an issue fire and a writeback to the same rd leave cnt and inflight unchanged. Saturation evaluates pre-update state, so issue_ready may be 0 even though a writeback frees a slot that cycle.

Same cycle, different registers: each register updates independently; inflight net change is -1, 0 or +1.

flush has priority over issue and writeback:
- All cnt and inflight are 0 the next cycle.
- The issue and writeback in the flush cycle are discarded, and wb_err is not set by them.
- The issue_ready value in the flush cycle is unconstrained.

Forwarding and hazard (combinational, per source s in {rs1, rs2}):
- Forward hit: exu_fwd_valid && s==exu_fwd_rd && s!=0 && cnt[s]==1. A single outstanding writer is required; with 2+ writers the EXU value may be stale, so forwarding is refused.
- Busy: cnt[s]!=0 && !forward hit.
- fwd1 = forward hit for rs1; fwd2 = forward hit for rs2.
- hazard = busy(rs1) || busy(rs2).

rf_table, inflight and the counters are registered; all updates occur on the rising clock edge.

Test Plan:
- Reset then idle -> rf_table=0, inflight=0, issue_ready=1, hazard=0, wb_err=0.
- Issue rd=5 twice, rs1=5, exu_fwd_valid=1, exu_fwd_rd=5 -> cnt[5]=2, rf_table[5]=1, fwd1=0, hazard=1. After one wb rd=5: cnt=1, fwd1=1, hazard=0.
- Issue rd=3 three times (CNT_W=2) -> fourth issue to rd=3 sees issue_ready=0. Issue to rd=7 is accepted (inflight 3→4). A further issue to rd=8 sees issue_ready=0 because inflight==4.
- Same cycle issue rd=6 and wb rd=6 with cnt[6]=1 -> cnt[6] stays 1, inflight unchanged. Issue rd=0 -> no state change.
- wb rd=9 with cnt[9]=0 -> wb_err=1 and stays 1 through later traffic; no counter changes.
- Load rd=2 and rd=4 pending, assert flush together with issue rd=2 and wb rd=4 -> next cycle rf_table=0, inflight=0. Assert reset low mid-traffic -> state clears immediately, without waiting for a clock edge.
